req_ack_master: RTL and testbench

REQ_ACK_MASTER -- requirements
Module: req_ack_master

---
 rtl/req_ack_master.sv | 99 +++++++++
 tb/tb_req_ack_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/req_ack_master.sv
// req_ack_master: writes a pattern over NUM_TXN words through a req/ack handshake, reads it back and counts mismatches
module req_ack_master #(
    parameter int N       = 0,
    parameter int NUM_TXN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ack,
    input  logic [31:0] rdata,
    output logic        req,
    output logic        cmd,
    output logic [31:0] wdata,
    output logic [31:0] addr,
    output logic        done,
    output logic [7:0]  err_cnt
);
    localparam logic [31:0] BASE = {N[3:0], 28'h0};
    localparam logic [31:0] PAT  = 32'hA5A5_A5A5;
    localparam logic [7:0]  LAST = 8'(NUM_TXN - 1);

    typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;

    state_t      state, state_d;
    logic [7:0]  idx, idx_d, nidx, err_d;
    logic [31:0] addr_d, wdata_d;
    logic        req_d, cmd_d, done_d, pend, pend_d, last, miss;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            req     <= 1'b0;
            cmd     <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            done    <= 1'b0;
            err_cnt <= '0;
            idx     <= '0;
            pend    <= 1'b0;
        end else begin
            state   <= state_d;
            req     <= req_d;
            cmd     <= cmd_d;
            addr    <= addr_d;
            wdata   <= wdata_d;
            done    <= done_d;
            err_cnt <= err_d;
            idx     <= idx_d;
            pend    <= pend_d;
        end
    end

    // addr still holds the read's address on the capture edge, so the expected pattern comes from it
    always_comb begin
        last    = idx == LAST;
        nidx    = last ? 8'd0 : idx + 8'd1;
        miss    = pend && rdata != (addr ^ PAT);
        err_d   = (miss && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
        state_d = state;
        req_d   = req;
        cmd_d   = cmd;
        addr_d  = addr;
        wdata_d = wdata;
        idx_d   = idx;
        done_d  = done;
        pend_d  = 1'b0;
        case (state)
            IDLE: begin
                state_d = WRITE;
                req_d   = 1'b1;
                cmd_d   = 1'b1;
                idx_d   = '0;
                addr_d  = BASE;
                wdata_d = BASE ^ PAT;
            end
            WRITE, READ: begin
                if (req && ack) begin
                    req_d   = 1'b0;
                    pend_d  = !cmd;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!cmd && last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cmd_d   = cmd && !last;
                    state_d = cmd_d ? WRITE : READ;
                    req_d   = 1'b1;
                    idx_d   = nidx;
                    addr_d  = BASE + {22'd0, nidx, 2'b00};
                    wdata_d = cmd_d ? addr_d ^ PAT : '0;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_req_ack_master.sv
// tb_req_ack_master: directed vectors plus a negedge-driven slave model for the req/ack master
module tb_req_ack_master;
    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    typedef struct {
        logic        a;
        logic        r;
        logic        c;
        logic [31:0] ad;
        logic [31:0] wd;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0, ack = 1'b0, ack3 = 1'b0;
    logic [31:0] rdata = '0, rdata3 = '0;
    logic        req, cmd, done, req3, cmd3, done3;
    logic [31:0] wdata, addr, wdata3, addr3;
    logic [7:0]  err_cnt, err3;
    int          tests = 0, fails = 0;
    vec_t        tab[9];

    always #5 clk = ~clk;

    req_ack_master dut (
        .clk(clk), .rst(rst), .ack(ack), .rdata(rdata), .req(req), .cmd(cmd),
        .wdata(wdata), .addr(addr), .done(done), .err_cnt(err_cnt)
    );

    req_ack_master #(.N(3), .NUM_TXN(4)) dut3 (
        .clk(clk), .rst(rst), .ack(ack3), .rdata(rdata3), .req(req3), .cmd(cmd3),
        .wdata(wdata3), .addr(addr3), .done(done3), .err_cnt(err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ea(input int k);
        return 32'(4 * (k % 16));
    endfunction

    function automatic logic [31:0] ew(input int k);
        return (k < 16) ? ea(k) ^ PAT : 32'h0;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        ack = 1'b0;
        rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Slave acts at each negedge; read data is presented the cycle after the read handshake only
    task automatic run(input int maxw, input int bad_a, input int bad_b, input int stop_k);
        int k = 0, w = 0, cyc = 0;
        logic req_p = 1'b0, ack_p = 1'b0, after = 1'b0, c_p = 1'b0;
        logic [31:0] a_p = '0, wd_p = '0;
        ack = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            rdata = 32'hDEAD_BEEF;
            if (req_p && ack_p) begin
                if (!c_p)
                    rdata = (a_p ^ PAT) ^ ((k - 16 == bad_a || k - 16 == bad_b) ? 32'h1 : 32'h0);
                k++;
                chk("gap_low", {31'd0, req}, 32'd0);
                after = 1'b1;
            end else if (after) begin
                after = 1'b0;
                if (k < 32) chk("gap_one_cycle", {31'd0, req}, 32'd1);
            end
            if (req && !req_p) begin
                if (k == stop_k) begin
                    ack = 1'b0;
                    return;
                end
                chk("cmd", {31'd0, cmd}, (k < 16) ? 32'd1 : 32'd0);
                chk("addr", addr, ea(k));
                chk("wdata", wdata, ew(k));
                w = $urandom_range(maxw, 0);
            end else if (req && req_p && !ack_p) begin
                chk("hold_cmd", {31'd0, cmd}, {31'd0, c_p});
                chk("hold_addr", addr, a_p);
                chk("hold_wdata", wdata, wd_p);
            end
            if (req) begin
                ack = (w == 0);
                if (w > 0) w--;
            end else begin
                ack = (maxw > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            req_p = req;
            ack_p = ack;
            a_p   = addr;
            wd_p  = wdata;
            c_p   = cmd;
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("txn_count", 32'(k), 32'd32);
    endtask

    initial begin
        tab[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tab[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5};
        tab[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5};
        tab[3] = '{1'b1, 1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5};
        tab[4] = '{1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5};
        tab[5] = '{1'b1, 1'b1, 1'b1, 32'h4, 32'hA5A5_A5A1};
        tab[6] = '{1'b0, 1'b0, 1'b1, 32'h4, 32'hA5A5_A5A1};
        tab[7] = '{1'b0, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5AD};
        tab[8] = '{1'b0, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5AD};

        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {24'd0, err_cnt}, 32'd0);

        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, tab[i].r});
            chk($sformatf("vec%0d_cmd", i), {31'd0, cmd}, {31'd0, tab[i].c});
            chk($sformatf("vec%0d_addr", i), addr, tab[i].ad);
            chk($sformatf("vec%0d_wdata", i), wdata, tab[i].wd);
            chk($sformatf("vec%0d_done", i), {31'd0, done}, 32'd0);
            ack = tab[i].a;
            @(negedge clk);
        end
        chk("n3_req", {31'd0, req3}, 32'd1);
        chk("n3_cmd", {31'd0, cmd3}, 32'd1);
        chk("n3_addr", addr3, 32'h3000_0000);
        chk("n3_wdata", wdata3, 32'h95A5_A5A5);

        do_reset();
        run(0, -1, -1, -1);
        chk("zero_wait_err", {24'd0, err_cnt}, 32'd0);
        ack = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("done_req", {31'd0, req}, 32'd0);
            chk("done_hold", {31'd0, done}, 32'd1);
        end
        chk("done_err", {24'd0, err_cnt}, 32'd0);

        do_reset();
        run(5, -1, -1, -1);
        chk("rand_wait_err", {24'd0, err_cnt}, 32'd0);

        do_reset();
        run(2, 2, 7, -1);
        chk("corrupt_err", {24'd0, err_cnt}, 32'd2);

        do_reset();
        run(3, -1, -1, 5);
        chk("pre_rst_addr", addr, 32'h14);
        #2 rst = 1'b0;
        #1;
        chk("async_req", {31'd0, req}, 32'd0);
        chk("async_cmd", {31'd0, cmd}, 32'd0);
        chk("async_addr", addr, 32'd0);
        chk("async_wdata", wdata, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(0, -1, -1, -1);
        chk("restart_err", {24'd0, err_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
